// File: rtl/display_scanner_pkg.sv
// ============================================================================
// Module  : display_scanner_pkg
// Brief   : Shared glyph and code constants for the multiplexed clock display.
// Revision: 1.0
// ============================================================================
`default_nettype none

package display_scanner_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] CODE_BLANK = 4'hF;

endpackage

`default_nettype wire

// File: rtl/display_scanner_seg_decoder.sv
// ============================================================================
// Module  : seg_decoder
// Brief   : Combinational 4-bit code to active-low {g,f,e,d,c,b,a} glyph.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg_decoder
    import display_scanner_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_DASH;
        case (code)
            4'd0:       seg_n = SEG_0;
            4'd1:       seg_n = SEG_1;
            4'd2:       seg_n = SEG_2;
            4'd3:       seg_n = SEG_3;
            4'd4:       seg_n = SEG_4;
            4'd5:       seg_n = SEG_5;
            4'd6:       seg_n = SEG_6;
            4'd7:       seg_n = SEG_7;
            4'd8:       seg_n = SEG_8;
            4'd9:       seg_n = SEG_9;
            CODE_BLANK: seg_n = SEG_BLANK;
            default:    seg_n = SEG_DASH;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/display_scanner.sv
// ============================================================================
// Module  : display_scanner
// Brief   : Four-digit multiplexed 7-segment scanner with snapshot, LZ blanking
//           and alarm flash.
// Revision: 1.0
// ============================================================================
`default_nettype none

module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int FLASH_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit_0,
    input  logic [3:0] digit_1,
    input  logic [3:0] digit_2,
    input  logic [3:0] digit_3,
    input  logic       blank,
    input  logic       lz_blank,
    input  logic       colon_en,
    input  logic       flash_en,
    output logic [3:0] anode_n,
    output logic [6:0] seg_n,
    output logic       colon_n,
    output logic       frame_done
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    localparam logic [PW-1:0] c_PRESC_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] c_PRESC_PENULT = PW'(SCAN_DIV - 2);
    localparam logic [FW-1:0] c_FLASH_LAST   = FW'(FLASH_FRAMES - 1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [FW-1:0] r_fcnt;
    logic          r_phase;
    logic [3:0]    r_digit [4];
    logic          r_blank;
    logic          r_lz;
    logic          r_colon;
    logic          r_flash;

    logic          w_guard;
    logic          w_frame_start;
    logic          w_slot_end;
    logic [3:0]    w_digit [4];
    logic          w_blank;
    logic          w_lz;
    logic          w_colon;
    logic          w_flash;
    logic          w_dark;
    logic          w_lz_hit;
    logic [3:0]    w_code;
    logic [6:0]    w_glyph;

    assign w_guard       = (r_presc == '0);
    assign w_frame_start = w_guard && (r_idx == 2'd0);
    assign w_slot_end    = (r_presc == c_PRESC_LAST);

    // During the slot-0 guard cycle the live inputs are the values being
    // latched, so slot 0 already shows the new snapshot.
    always_comb begin
        w_digit = r_digit;
        w_blank = r_blank;
        w_lz    = r_lz;
        w_colon = r_colon;
        w_flash = r_flash;
        if (w_frame_start) begin
            w_digit[0] = digit_0;
            w_digit[1] = digit_1;
            w_digit[2] = digit_2;
            w_digit[3] = digit_3;
            w_blank    = blank;
            w_lz       = lz_blank;
            w_colon    = colon_en;
            w_flash    = flash_en;
        end
    end

    assign w_code   = w_digit[r_idx];
    assign w_dark   = w_blank || (w_flash && r_phase);
    assign w_lz_hit = (r_idx == 2'd3) && w_lz && (w_digit[3] == 4'd0);

    seg_decoder u_seg_decoder (
        .code  (w_code),
        .seg_n (w_glyph)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc    <= '0;
            r_idx      <= 2'd0;
            r_fcnt     <= '0;
            r_phase    <= 1'b0;
            for (int i = 0; i < 4; i++) r_digit[i] <= CODE_BLANK;
            r_blank    <= 1'b0;
            r_lz       <= 1'b0;
            r_colon    <= 1'b0;
            r_flash    <= 1'b0;
            anode_n    <= 4'hF;
            seg_n      <= SEG_BLANK;
            colon_n    <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_presc <= '0;
                r_idx   <= r_idx + 2'd1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            if (w_frame_start) begin
                r_digit <= w_digit;
                r_blank <= w_blank;
                r_lz    <= w_lz;
                r_colon <= w_colon;
                r_flash <= w_flash;
            end

            // Drive lands at the end of the guard cycle; anodes drop one
            // cycle before the next slot so segments switch while dark.
            if (w_guard) begin
                anode_n <= w_dark ? 4'hF : ~(4'b0001 << r_idx);
                seg_n   <= (w_dark || w_lz_hit) ? SEG_BLANK : w_glyph;
                colon_n <= ~(w_colon && !w_dark);
            end else if (w_slot_end) begin
                anode_n <= 4'hF;
            end

            frame_done <= (r_idx == 2'd3) && (r_presc == c_PRESC_PENULT);

            if (!flash_en) begin
                r_fcnt  <= '0;
                r_phase <= 1'b0;
            end else if (w_slot_end && (r_idx == 2'd3)) begin
                if (r_fcnt == c_FLASH_LAST) begin
                    r_fcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_fcnt  <= r_fcnt + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_display_scanner.sv
// ============================================================================
// Module  : tb_display_scanner
// Brief   : Scoreboard bench for display_scanner with SCAN_DIV=4, FLASH_FRAMES=2.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_display_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digit_0, digit_1, digit_2, digit_3;
    logic       blank, lz_blank, colon_en, flash_en;
    logic [3:0] anode_n;
    logic [6:0] seg_n;
    logic       colon_n;
    logic       frame_done;

    display_scanner #(.SCAN_DIV(4), .FLASH_FRAMES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .digit_0    (digit_0),
        .digit_1    (digit_1),
        .digit_2    (digit_2),
        .digit_3    (digit_3),
        .blank      (blank),
        .lz_blank   (lz_blank),
        .colon_en   (colon_en),
        .flash_en   (flash_en),
        .anode_n    (anode_n),
        .seg_n      (seg_n),
        .colon_n    (colon_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       col;
        logic       fd;
        logic       mask;
    } exp_t;

    exp_t  sb[$];
    int    n_vec = 0;
    int    n_bad = 0;
    bit    mon_en = 1'b0;
    string cur_test = "none";

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hF: return 7'h7F;
            default: return 7'h3F;
        endcase
    endfunction

    // Expected 16 cycles of one frame; segments/colon are checked only while
    // a digit is driven (guard cycles carry the previous slot's glyph).
    task automatic push_frame(input logic [3:0] d3, d2, d1, d0,
                              input logic lz, input logic col, input logic dark);
        logic [3:0] d[4];
        exp_t e;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                e.an   = (c == 0 || dark) ? 4'hF : ~(4'b0001 << s);
                if (dark)                           e.seg = 7'h7F;
                else if (s == 3 && lz && d[3] == 0) e.seg = 7'h7F;
                else                                e.seg = glyph(d[s]);
                e.col  = dark ? 1'b1 : ~col;
                e.fd   = (s == 3 && c == 3);
                e.mask = (c != 0);
                sb.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL %s scoreboard_empty: no expected entry at t=%0t", cur_test, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (anode_n !== e.an || frame_done !== e.fd ||
                    (e.mask && (seg_n !== e.seg || colon_n !== e.col))) begin
                    n_bad++;
                    $display("FAIL %s cycle_out t=%0t: got an=%h seg=%h col=%b fd=%b, want an=%h seg=%h col=%b fd=%b (mask=%b)",
                             cur_test, $time, anode_n, seg_n, colon_n, frame_done,
                             e.an, e.seg, e.col, e.fd, e.mask);
                end
            end
        end
    end

    task automatic set_inputs(input logic [3:0] d3, d2, d1, d0,
                              input logic lz, input logic bl, input logic col);
        digit_3 = d3; digit_2 = d2; digit_1 = d1; digit_0 = d0;
        lz_blank = lz; blank = bl; colon_en = col;
    endtask

    // Called #1 after the edge that starts a frame's slot-0 guard cycle.
    task automatic run_frame(input logic [3:0] d3, d2, d1, d0,
                             input logic lz, input logic bl, input logic col,
                             input logic flash_dark);
        set_inputs(d3, d2, d1, d0, lz, bl, col);
        push_frame(d3, d2, d1, d0, lz, col, bl | flash_dark);
        mon_en = 1'b1;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_vec++;
        if (anode_n !== 4'hF || seg_n !== 7'h7F || colon_n !== 1'b1 || frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got an=%h seg=%h col=%b fd=%b, want an=f seg=7f col=1 fd=0",
                     tag, anode_n, seg_n, colon_n, frame_done);
        end
    endtask

    task automatic test_reset();
        cur_test = "reset";
        reset = 1'b1;
        flash_en = 1'b0;
        set_inputs(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        reset = 1'b0;
        run_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_decode();
        cur_test = "decode";
        run_frame(4'd0, 4'hB, 4'hC, 4'hD, 1'b1, 1'b0, 1'b1, 1'b0);
        run_frame(4'd0, 4'd9, 4'd8, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(4'd6, 4'd5, 4'hF, 4'hA, 1'b1, 1'b0, 1'b1, 1'b0);
        run_frame(4'hE, 4'd3, 4'd2, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_no_tearing();
        cur_test = "no_tearing";
        set_inputs(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0);
        push_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        digit_0 = 4'd9;
        digit_3 = 4'd7;
        colon_en = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        run_frame(4'd7, 4'd2, 4'd3, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_blank();
        cur_test = "blank";
        run_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        run_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_flash();
        cur_test = "flash";
        mon_en = 1'b0;
        sb.delete();
        reset = 1'b1;
        flash_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        run_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 1'b1, 1'b1);
        run_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 1'b1, 1'b1);
        run_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        flash_en = 1'b0;
        run_frame(4'd5, 4'd6, 4'd7, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        cur_test = "reset_mid";
        set_inputs(4'd8, 4'd8, 4'd8, 4'd8, 1'b0, 1'b0, 1'b1);
        push_frame(4'd8, 4'd8, 4'd8, 4'd8, 1'b0, 1'b1, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        mon_en = 1'b0;
        sb.delete();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check_reset_outputs("reset_mid_outputs");
        end
        reset = 1'b0;
        run_frame(4'd2, 4'd0, 4'd5, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        flash_en = 1'b0;
        set_inputs(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_decode();
        test_no_tearing();
        test_blank();
        test_flash();
        test_reset_mid_frame();
        mon_en = 1'b0;
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
